// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared feeder state encoding and shifter word targets
package spi_slave_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LOAD, ST_STREAM, ST_LAST} feeder_state_t;
    localparam logic [7:0] SPI_TX_CNT_SINGLE = 8'd31;
    localparam logic [7:0] SPI_TX_CNT_QUAD = 8'd7;
    function automatic logic [7:0] tx_target(input logic quad);
        return quad ? SPI_TX_CNT_QUAD : SPI_TX_CNT_SINGLE;
    endfunction
endpackage

// File: rtl/spi_slave_tx_feeder_if.sv
// spi_slave_tx_feeder_if: TX FIFO read side and TX shifter load side of the feeder
interface spi_slave_tx_feeder_if;
    logic [31:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [31:0] tx_data;
    logic        tx_data_valid;
    logic [7:0]  tx_counter;
    logic        tx_counter_upd;
    logic        tx_done;
    modport master (
        input  fifo_data, fifo_valid, tx_done,
        output fifo_ready, tx_data, tx_data_valid, tx_counter, tx_counter_upd
    );
    modport slave (
        output fifo_data, fifo_valid, tx_done,
        input  fifo_ready, tx_data, tx_data_valid, tx_counter, tx_counter_upd
    );
endinterface

// File: rtl/spi_tx_prefetch_reg.sv
// spi_tx_prefetch_reg: one-entry word register; flush beats push, push beats pop
module spi_tx_prefetch_reg (
    input  logic        sclk,
    input  logic        rstn,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        flush,
    output logic        valid,
    output logic [31:0] data
);
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            data <= '0;
        end else begin
            valid <= flush ? 1'b0 : push ? 1'b1 : pop ? 1'b0 : valid;
            if (push) data <= push_data;
        end
    end
endmodule

// File: rtl/spi_slave_tx_feeder.sv
// spi_slave_tx_feeder: feeds TX FIFO words into the SPI slave shifter with a one-word prefetch.
// Define SPI_TX_UNDERRUN_FILL_EN to send FILL_WORD on underrun instead of letting the shifter emit zeros.
module spi_slave_tx_feeder
    import spi_slave_pkg::*;
#(
    parameter logic [31:0] FILL_WORD = 32'hDEAD_BEEF,
    parameter int          CNT_W = 16
) (
    input  logic             sclk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             en_quad,
    input  logic             abort,
    output logic             busy,
    output logic             underrun,
    output logic [CNT_W-1:0] words_sent,
    spi_slave_tx_feeder_if.master bus
);
`ifdef SPI_TX_UNDERRUN_FILL_EN
    localparam logic FILL_EN = 1'b1;
`else
    localparam logic FILL_EN = 1'b0;
`endif
    feeder_state_t state, next;
    logic [CNT_W-1:0] words_left;
    logic [31:0] pf_data;
    logic pf_valid, pf_pop, sent_inc, accept;

    assign accept = state == ST_IDLE && start && num_words != '0;
    assign busy = state != ST_IDLE;

    // Leaving for IDLE always drops the prefetch so a new transfer starts clean
    spi_tx_prefetch_reg u_pf (
        .sclk(sclk),
        .rstn(rstn),
        .push(bus.fifo_valid && bus.fifo_ready),
        .push_data(bus.fifo_data),
        .pop(pf_pop),
        .flush(next == ST_IDLE),
        .valid(pf_valid),
        .data(pf_data)
    );

    always_comb begin
        next = state;
        bus.fifo_ready = 1'b0;
        bus.tx_data = '0;
        bus.tx_data_valid = 1'b0;
        bus.tx_counter_upd = 1'b0;
        pf_pop = 1'b0;
        sent_inc = 1'b0;
        underrun = 1'b0;
        case (state)
            ST_IDLE: next = accept ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                bus.fifo_ready = !abort;
                next = bus.fifo_valid ? ST_LOAD : ST_FETCH;
            end
            ST_LOAD: begin
                bus.tx_data = pf_data;
                bus.tx_data_valid = !abort;
                bus.tx_counter_upd = !abort;
                pf_pop = 1'b1;
                sent_inc = !abort;
                next = words_left == CNT_W'(1) ? ST_LAST : ST_STREAM;
            end
            ST_STREAM: begin
                bus.fifo_ready = !pf_valid && !abort;
                if (bus.tx_done && !abort) begin
                    sent_inc = 1'b1;
                    pf_pop = pf_valid;
                    underrun = !pf_valid;
                    bus.tx_data = pf_valid ? pf_data : FILL_WORD;
                    bus.tx_data_valid = pf_valid || FILL_EN;
                    next = words_left == CNT_W'(1) ? ST_LAST : ST_STREAM;
                end
            end
            ST_LAST: next = bus.tx_done ? ST_IDLE : ST_LAST;
            default: next = ST_IDLE;
        endcase
        if (abort) next = ST_IDLE;
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            words_left <= '0;
            words_sent <= '0;
            bus.tx_counter <= SPI_TX_CNT_QUAD;
        end else begin
            state <= next;
            if (accept) begin
                words_left <= num_words;
                words_sent <= '0;
                bus.tx_counter <= tx_target(en_quad);
            end else if (sent_inc) begin
                words_left <= words_left - CNT_W'(1);
                words_sent <= words_sent + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_tx_feeder.sv
// tb_spi_slave_tx_feeder: directed and randomized transfers against a FIFO queue and shifter model
module tb_spi_slave_tx_feeder;
    localparam int CNT_W = 16;
`ifdef SPI_TX_UNDERRUN_FILL_EN
    localparam logic FILL_ON = 1'b1;
`else
    localparam logic FILL_ON = 1'b0;
`endif
    logic sclk = 1'b0, rstn = 1'b0, start = 1'b0, en_quad = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic busy, underrun;
    logic [CNT_W-1:0] words_sent;

    spi_slave_tx_feeder_if bus();
    spi_slave_tx_feeder #(.FILL_WORD(32'hDEAD_BEEF), .CNT_W(CNT_W)) dut (
        .sclk(sclk), .rstn(rstn), .start(start), .num_words(num_words), .en_quad(en_quad),
        .abort(abort), .busy(busy), .underrun(underrun), .words_sent(words_sent), .bus(bus)
    );

    always #5 sclk = ~sclk;

    int n_total = 0, n_fail = 0, cyc = 0;
    int n_under = 0, n_valid = 0, n_upd = 0, rd_ptr = 0, fifo_skip = 0;
    int g0, u0, v0, p0, r0;
    logic [31:0] fifo_mem[$], got_q[$], exp_q[$];
    int got_cyc[$];
    logic fifo_gaps = 1'b0, fifo_en;
    logic [7:0] last_tgt, s_tgt, sh_tgt;
    logic u_valid;
    logic [31:0] u_data;
    logic s_pop, s_upd, s_done, sh_active = 1'b0;
    int sh_cnt = 0;

    // Shifter model: counts target..0, strobing done at 0 and rearming with the same target
    assign bus.tx_done = sh_active && sh_cnt == 0;

    always @(negedge sclk) begin
        cyc++;
        s_pop = rstn && bus.fifo_valid && bus.fifo_ready;
        s_upd = rstn && bus.tx_counter_upd;
        s_done = rstn && bus.tx_done;
        s_tgt = bus.tx_counter;
        if (rstn) begin
            if (bus.tx_data_valid) n_valid++;
            if (bus.tx_data_valid && !underrun) begin
                got_q.push_back(bus.tx_data);
                got_cyc.push_back(cyc);
            end
            if (underrun) begin
                n_under++;
                u_valid = bus.tx_data_valid;
                u_data = bus.tx_data;
            end
            if (bus.tx_counter_upd) begin
                n_upd++;
                last_tgt = bus.tx_counter;
            end
        end
    end

    always @(posedge sclk) begin
        #1;
        if (s_pop) rd_ptr++;
        if (rd_ptr < fifo_skip) rd_ptr = fifo_skip;
        fifo_en = !fifo_gaps || $urandom_range(0, 9) < 3;
        bus.fifo_valid = fifo_en && rd_ptr < fifo_mem.size();
        bus.fifo_data = rd_ptr < fifo_mem.size() ? fifo_mem[rd_ptr] : 32'h0;
        if (!rstn || !busy) sh_active = 1'b0;
        else if (s_upd) begin
            sh_active = 1'b1;
            sh_cnt = int'(s_tgt);
            sh_tgt = s_tgt;
        end else if (sh_active) sh_cnt = s_done ? int'(sh_tgt) : sh_cnt - 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sclk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_fifo();
        fifo_skip = fifo_mem.size();
        exp_q.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic snap();
        g0 = got_q.size();
        u0 = n_under;
        v0 = n_valid;
        p0 = n_upd;
        r0 = rd_ptr;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) tick();
        check("xfer_done", busy, 1'b0);
    endtask

    task automatic run_xfer(input int n, input logic q);
        start = 1'b1;
        num_words = CNT_W'(n);
        en_quad = q;
        tick();
        start = 1'b0;
        wait_idle();
    endtask

    task automatic check_words(input int n);
        check("word_count", got_q.size() - g0, n);
        for (int k = 0; k < n && g0 + k < got_q.size(); k++) check("word", got_q[g0 + k], exp_q[k]);
    endtask

    initial begin
        tick(2);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_ready", bus.fifo_ready, 1'b0);
        check("rst_valid", bus.tx_data_valid, 1'b0);
        check("rst_upd", bus.tx_counter_upd, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_tx_data", bus.tx_data, 32'h0);
        check("rst_tx_counter", bus.tx_counter, 8'd7);
        check("rst_words_sent", words_sent, '0);
        rstn = 1'b1;
        tick(2);

        new_fifo();
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        push_word(32'h3333_3333);
        tick();
        snap();
        run_xfer(3, 1'b0);
        check("single_upd_count", n_upd - p0, 1);
        check("single_target", last_tgt, 8'd31);
        check_words(3);
        check("single_sent", words_sent, 3);
        check("single_underrun", n_under - u0, 0);

        new_fifo();
        push_word($urandom);
        push_word($urandom);
        tick();
        snap();
        run_xfer(2, 1'b1);
        check("quad_target", last_tgt, 8'd7);
        check_words(2);
        check("quad_reload_gap", got_cyc[g0 + 1] - got_cyc[g0], 8);
        check("quad_sent", words_sent, 2);

        new_fifo();
        push_word(32'hA5A5_0001);
        tick();
        snap();
        run_xfer(2, 1'b0);
        check("ur_pulses", n_under - u0, 1);
        check("ur_sent", words_sent, 2);
        check_words(1);
        check("ur_valid", u_valid, FILL_ON);
        check("ur_valid_total", n_valid - v0, 1 + int'(FILL_ON));
`ifdef SPI_TX_UNDERRUN_FILL_EN
        check("ur_fill_word", u_data, 32'hDEAD_BEEF);
`endif

        new_fifo();
        for (int i = 0; i < 4; i++) push_word($urandom);
        tick();
        snap();
        start = 1'b1;
        num_words = CNT_W'(4);
        en_quad = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && got_q.size() == g0; i++) tick();
        check("abort_first_word", got_q.size() - g0, 1);
        tick(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_fifo_ready", bus.fifo_ready, 1'b0);
        check("abort_sent", words_sent, 1);
        v0 = n_valid;
        tick(40);
        check("abort_quiet", n_valid - v0, 0);

        new_fifo();
        push_word($urandom);
        push_word($urandom);
        tick();
        snap();
        start = 1'b1;
        num_words = '0;
        tick();
        start = 1'b0;
        tick(3);
        check("zero_busy", busy, 1'b0);
        check("zero_pops", rd_ptr - r0, 0);
        check("zero_sent_kept", words_sent, 1);
        start = 1'b1;
        num_words = CNT_W'(2);
        en_quad = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        start = 1'b1;
        num_words = CNT_W'(5);
        tick();
        start = 1'b0;
        check("busy_start_busy", busy, 1'b1);
        wait_idle();
        check("busy_start_sent", words_sent, 2);
        check("busy_start_pops", rd_ptr - r0, 2);
        check("busy_start_upd", n_upd - p0, 1);
        check_words(2);

        new_fifo();
        for (int i = 0; i < 3; i++) push_word($urandom);
        tick();
        start = 1'b1;
        num_words = CNT_W'(3);
        en_quad = 1'b1;
        tick();
        start = 1'b0;
        tick(5);
        rstn = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_fifo_ready", bus.fifo_ready, 1'b0);
        check("arst_valid", bus.tx_data_valid, 1'b0);
        check("arst_upd", bus.tx_counter_upd, 1'b0);
        check("arst_tx_data", bus.tx_data, 32'h0);
        check("arst_tx_counter", bus.tx_counter, 8'd7);
        check("arst_sent", words_sent, '0);
        tick(2);
        rstn = 1'b1;
        tick();
        new_fifo();
        push_word($urandom);
        push_word($urandom);
        tick();
        snap();
        run_xfer(2, 1'b0);
        check_words(2);
        check("post_rst_sent", words_sent, 2);

        for (int it = 0; it < 8; it++) begin
            int n;
            logic q;
            n = int'($urandom_range(1, 6));
            q = 1'($urandom_range(0, 1));
            fifo_gaps = it >= 4;
            new_fifo();
            for (int i = 0; i < n; i++) push_word($urandom);
            tick();
            snap();
            run_xfer(n, q);
            check("rand_sent", words_sent, n);
            check("rand_target", last_tgt, q ? 8'd7 : 8'd31);
            if (!fifo_gaps) begin
                check_words(n);
                check("rand_underrun", n_under - u0, 0);
            end else begin
                check("rand_slots", (got_q.size() - g0) + (n_under - u0), n);
                check_words(got_q.size() - g0);
            end
        end
        fifo_gaps = 1'b0;

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
